// File: rtl/bit_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package bit_serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width of the bit counter that walks positions 0..w-1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first serial adder: one bit pair per clock through a single full_adder,
// registered sum/cout and a one-cycle done pulse after WIDTH cycles.
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic [WIDTH-1:0] s_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             last;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign s_nx = {fa_s, s_sr[WIDTH-1:1]};
  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == RUN);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sr  <= a;
          b_sr  <= b;
          carry <= cin;
          cnt   <= '0;
        end
      end else begin
        a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
        s_sr  <= s_nx;
        carry <= fa_c;
        cnt   <= cnt + 1'b1;
        if (last) begin
          sum  <= s_nx;
          cout <= fa_c;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder at WIDTH=8 and WIDTH=16.
module tb_bit_serial_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;

  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  bit_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full 8-bit transaction: start, watch busy, measure latency, check result.
  task automatic add8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic cv, input logic [7:0] esum, input logic ecout);
    int lat;
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 'x; b8 = 'x; cin8 = 1'bx;
    chk({tag, "_busy0"}, 32'(busy8), 32'd1);
    lat = 0;
    do begin
      tick();
      lat++;
      if (!done8 && busy8 !== 1'b1) chk({tag, "_busy_run"}, 32'(busy8), 32'd1);
    end while (!done8 && lat < 40);
    chk({tag, "_lat"},  32'(lat),   32'd8);
    chk({tag, "_done"}, 32'(done8), 32'd1);
    chk({tag, "_busy"}, 32'(busy8), 32'd0);
    chk({tag, "_sum"},  32'(sum8),  32'(esum));
    chk({tag, "_cout"}, 32'(cout8), 32'(ecout));
    tick();
    chk({tag, "_pulse"}, 32'(done8), 32'd0);
  endtask

  task automatic add16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input logic [15:0] esum, input logic ecout);
    int lat;
    a16 = av; b16 = bv; cin16 = cv; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done16 && lat < 60);
    chk({tag, "_lat"},  32'(lat),    32'd16);
    chk({tag, "_busy"}, 32'(busy16), 32'd0);
    chk({tag, "_sum"},  32'(sum16),  32'(esum));
    chk({tag, "_cout"}, 32'(cout16), 32'(ecout));
  endtask

  initial begin
    int lat, ndone;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] rsum;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum",  32'(sum8),  32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    chk("rst_sum16", 32'(sum16), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy8), 32'd0);

    add8("basic",  8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    add8("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    add8("allone", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    add8("cin",    8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    add8("mixed",  8'h80, 8'h7F, 1'b1, 8'h00, 1'b1);

    // Start while busy must be ignored.
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 3;
    do begin
      tick();
      lat++;
    end while (!done8 && lat < 40);
    chk("ign_lat", 32'(lat),  32'd8);
    chk("ign_sum", 32'(sum8), 32'h30);
    ndone = 0;
    repeat (20) begin
      tick();
      if (done8) ndone++;
    end
    chk("ign_nodone", 32'(ndone), 32'd0);

    // Back-to-back: new start issued in the done cycle.
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done8 && lat < 40);
    chk("b2b_lat1", 32'(lat),  32'd8);
    chk("b2b_sum1", 32'(sum8), 32'h77);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("b2b_busy", 32'(busy8), 32'd1);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done8 && lat < 40);
    chk("b2b_lat2", 32'(lat),  32'd8);
    chk("b2b_sum2", 32'(sum8), 32'h10);

    // Reset mid-operation.
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy8), 32'd0);
    chk("mrst_done", 32'(done8), 32'd0);
    chk("mrst_sum",  32'(sum8),  32'd0);
    chk("mrst_cout", 32'(cout8), 32'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      tick();
      if (done8) ndone++;
    end
    chk("mrst_nodone", 32'(ndone), 32'd0);
    chk("mrst_sumhold", 32'(sum8), 32'd0);
    add8("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // Random operands against a + b + cin.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rsum = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      add8("rand", ra, rb, rc, rsum[7:0], rsum[8]);
    end

    add16("w16_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    add16("w16_mix",    16'h1234, 16'hABCD, 1'b1, 16'hBE02, 1'b0);
    add16("w16_msb",    16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    add16("w16_all",    16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
